// File: rtl/onewire_pkg.sv
// onewire_pkg: shared definitions for the byte-level 1-Wire master.
//   - cmd_op encodings (bus reset, write byte, read byte, reserved)
//   - sequencer state enumeration
//   - standard-speed timing constants in microseconds
//   - Dallas CRC8 polynomial (reflected) and a single-bit update helper
package onewire_pkg;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RST_LOW  = 3'd1,
    ST_RST_WAIT = 3'd2,
    ST_SLOT_LOW = 3'd3,
    ST_SLOT_REL = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  // Standard-speed timing, microseconds.
  localparam int T_RSTL_DEF_US = 480;  // reset low and reset recovery window
  localparam int T_PDS_DEF_US  = 70;   // presence sample point after release
  localparam int T_SLOT_DEF_US = 70;   // full slot including recovery
  localparam int T_LOW0_US     = 60;   // low time when writing a 0
  localparam int T_RDS_US      = 15;   // read sample point from slot start
  localparam int T_LOW1_US     = 6;    // low time when writing a 1 or starting a read

  // x^8 + x^5 + x^4 + 1, bit-reflected.
  localparam logic [7:0] CRC8_POLY = 8'h8C;

  // One LSB-first CRC8 step for a single data bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic [7:0] nxt;
    nxt = {1'b0, crc[7:1]};
    if (crc[0] ^ din) begin
      nxt = nxt ^ CRC8_POLY;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/onewire_crc8.sv
// onewire_crc8: bit-serial Dallas CRC8 accumulator (used only when
// ONEWIRE_CRC_EN is defined; the file is empty otherwise).
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset (clears the CRC)
//   clr  in   synchronous clear (start of a new bus transaction)
//   en   in   fold din into the CRC this cycle
//   din  in   data bit, LSB-first order
//   crc  out  current CRC value
`ifdef ONEWIRE_CRC_EN
module onewire_crc8
  import onewire_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic [7:0] crc_r;

  // CRC register: clear wins over update.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc_r <= 8'h00;
    end else if (en) begin
      crc_r <= crc8_step(crc_r, din);
    end else begin
      crc_r <= crc_r;
    end
  end

  assign crc = crc_r;

endmodule
`endif

// File: rtl/onewire_master.sv
// onewire_master: byte-level 1-Wire bus master driving an open-drain pin.
// Optional feature macro: ONEWIRE_CRC_EN (Dallas CRC8 over read bits on crc_o;
// without it crc_o is tied to zero).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only while idle)
//   cmd_op[1:0], cmd_data[7:0]  00 reset, 01 write, 10 read, 11 reserved
//   rsp_valid                one-cycle completion pulse
//   rsp_data[7:0]            last byte read
//   rsp_presence             presence seen on the last bus reset
//   rsp_error                bus stuck low, or reserved op
//   I_ONE_WIRE / O_ONE_WIRE  raw bus level in / 0 = pull low, 1 = release
//   crc_o[7:0]               CRC8 of read bytes
module onewire_master
  import onewire_pkg::*;
#(
  parameter int CLKS_PER_US = 12,
  parameter int T_RSTL_US   = T_RSTL_DEF_US,
  parameter int T_PDS_US    = T_PDS_DEF_US,
  parameter int T_SLOT_US   = T_SLOT_DEF_US
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_presence,
  output logic       rsp_error,
  input  logic       I_ONE_WIRE,
  output logic       O_ONE_WIRE,
  output logic [7:0] crc_o
);

  localparam int CW = $clog2(T_RSTL_US * CLKS_PER_US + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  // Reload values are duration-1; each phase ends when the counter reads 0.
  localparam logic [CW-1:0] RL_RSTL  = CW'(T_RSTL_US * CLKS_PER_US - 1);
  localparam logic [CW-1:0] RL_LOW0  = CW'(T_LOW0_US * CLKS_PER_US - 1);
  localparam logic [CW-1:0] RL_LOW1  = CW'(T_LOW1_US * CLKS_PER_US - 1);
  localparam logic [CW-1:0] RL_REL0  = CW'((T_SLOT_US - T_LOW0_US) * CLKS_PER_US - 1);
  localparam logic [CW-1:0] RL_REL1  = CW'((T_SLOT_US - T_LOW1_US) * CLKS_PER_US - 1);
  // Counter values at which samples are taken, measured from phase start.
  localparam logic [CW-1:0] AT_PDS   = CW'((T_RSTL_US - T_PDS_US) * CLKS_PER_US - 1);
  // Release phase always starts 6us into a read slot, so the 15us point is a
  // fixed distance from the end of the slot.
  localparam logic [CW-1:0] AT_RDS   = CW'((T_SLOT_US - T_RDS_US) * CLKS_PER_US - 1);

  state_t          state_r, state_n;
  logic [CW-1:0]   cnt_r, cnt_n;
  logic [1:0]      op_r, op_n;
  logic [7:0]      shift_r, shift_n;
  logic [2:0]      bit_cnt_r, bit_n;
  logic            pres_r, pres_n;
  logic            err_r, err_n;
  logic            sync1_r, sync2_r;
  logic            bus_s, short_s;
  logic [7:0]      crc_s;
  logic            o_wire_r, wire_n;
  logic            ready_r, ready_n;
  logic            vld_r, vld_n;
  logic [7:0]      data_r, data_n;
  logic            pres_o_r, pres_o_n;
  logic            err_o_r, err_o_n;
  logic [7:0]      crc_o_r, crc_n;
`ifdef ONEWIRE_CRC_EN
  logic            crc_clr_s, crc_en_s;
`endif

  assign bus_s   = sync2_r;
  // Short low phase: read slots and write-1 slots.
  assign short_s = (op_r == OP_READ) || shift_r[0];

`ifdef ONEWIRE_CRC_EN
  onewire_crc8 u_crc (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr_s),
    .en  (crc_en_s),
    .din (bus_s),
    .crc (crc_s)
  );
`else
  assign crc_s = 8'h00;
`endif

  // Next-state, timing counter and datapath decisions for the slot sequencer.
  always_comb begin
    state_n = state_r;
    cnt_n   = (cnt_r != CNT_ZERO) ? (cnt_r - CNT_ONE) : cnt_r;
    op_n    = op_r;
    shift_n = shift_r;
    bit_n   = bit_cnt_r;
    pres_n  = pres_r;
    err_n   = err_r;
`ifdef ONEWIRE_CRC_EN
    crc_clr_s = 1'b0;
    crc_en_s  = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && ready_r) begin
          op_n    = cmd_op;
          shift_n = cmd_data;
          bit_n   = 3'd0;
          pres_n  = 1'b0;
          err_n   = 1'b0;
          case (cmd_op)
            OP_RESET: begin
              state_n = ST_RST_LOW;
              cnt_n   = RL_RSTL;
`ifdef ONEWIRE_CRC_EN
              crc_clr_s = 1'b1;
`endif
            end
            OP_WRITE: begin
              state_n = ST_SLOT_LOW;
              cnt_n   = cmd_data[0] ? RL_LOW1 : RL_LOW0;
            end
            OP_READ: begin
              state_n = ST_SLOT_LOW;
              cnt_n   = RL_LOW1;
            end
            default: begin
              state_n = ST_DONE;
              err_n   = 1'b1;
            end
          endcase
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RST_LOW: begin
        if (cnt_r == CNT_ZERO) begin
          state_n = ST_RST_WAIT;
          cnt_n   = RL_RSTL;
        end else begin
          state_n = ST_RST_LOW;
        end
      end
      ST_RST_WAIT: begin
        if (cnt_r == AT_PDS) begin
          pres_n = ~bus_s;
        end else begin
          pres_n = pres_r;
        end
        if (cnt_r == CNT_ZERO) begin
          err_n   = ~bus_s;
          state_n = ST_DONE;
        end else begin
          state_n = ST_RST_WAIT;
        end
      end
      ST_SLOT_LOW: begin
        if (cnt_r == CNT_ZERO) begin
          state_n = ST_SLOT_REL;
          cnt_n   = short_s ? RL_REL1 : RL_REL0;
        end else begin
          state_n = ST_SLOT_LOW;
        end
      end
      ST_SLOT_REL: begin
        if ((op_r == OP_READ) && (cnt_r == AT_RDS)) begin
          shift_n = {bus_s, shift_r[7:1]};
`ifdef ONEWIRE_CRC_EN
          crc_en_s = 1'b1;
`endif
        end else begin
          shift_n = shift_r;
        end
        if (cnt_r == CNT_ZERO) begin
          // Bus still low after recovery means something is holding it.
          if (!bus_s) begin
            err_n = 1'b1;
          end else begin
            err_n = err_r;
          end
          if (bit_cnt_r == 3'd7) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_SLOT_LOW;
            bit_n   = bit_cnt_r + 3'd1;
            if (op_r == OP_READ) begin
              cnt_n = RL_LOW1;
            end else begin
              shift_n = {1'b0, shift_r[7:1]};
              cnt_n   = shift_r[1] ? RL_LOW1 : RL_LOW0;
            end
          end
        end else begin
          state_n = ST_SLOT_REL;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Output register inputs, derived from the upcoming state so every pin is a flop.
  always_comb begin
    wire_n   = ~((state_n == ST_RST_LOW) || (state_n == ST_SLOT_LOW));
    ready_n  = (state_n == ST_IDLE);
    vld_n    = (state_n == ST_DONE);
    data_n   = data_r;
    pres_o_n = pres_o_r;
    err_o_n  = err_o_r;
    crc_n    = crc_o_r;
    if (state_n == ST_DONE) begin
      err_o_n = err_n;
      crc_n   = crc_s;
      if (op_n == OP_READ) begin
        data_n = shift_n;
      end else begin
        data_n = data_r;
      end
      if (op_n == OP_RESET) begin
        pres_o_n = pres_n;
      end else begin
        pres_o_n = pres_o_r;
      end
    end else begin
      err_o_n = err_o_r;
    end
  end

  // State, timing, synchronizer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      op_r      <= OP_RESET;
      shift_r   <= 8'h00;
      bit_cnt_r <= 3'd0;
      pres_r    <= 1'b0;
      err_r     <= 1'b0;
      sync1_r   <= 1'b1;
      sync2_r   <= 1'b1;
      o_wire_r  <= 1'b1;
      ready_r   <= 1'b1;
      vld_r     <= 1'b0;
      data_r    <= 8'h00;
      pres_o_r  <= 1'b0;
      err_o_r   <= 1'b0;
      crc_o_r   <= 8'h00;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      op_r      <= op_n;
      shift_r   <= shift_n;
      bit_cnt_r <= bit_n;
      pres_r    <= pres_n;
      err_r     <= err_n;
      sync1_r   <= I_ONE_WIRE;
      sync2_r   <= sync1_r;
      o_wire_r  <= wire_n;
      ready_r   <= ready_n;
      vld_r     <= vld_n;
      data_r    <= data_n;
      pres_o_r  <= pres_o_n;
      err_o_r   <= err_o_n;
      crc_o_r   <= crc_n;
    end
  end

  assign O_ONE_WIRE   = o_wire_r;
  assign cmd_ready    = ready_r;
  assign rsp_valid    = vld_r;
  assign rsp_data     = data_r;
  assign rsp_presence = pres_o_r;
  assign rsp_error    = err_o_r;
  assign crc_o        = crc_o_r;

endmodule

// File: tb/tb_onewire_master.sv
// tb_onewire_master: randomized, scoreboard-checked bench for onewire_master
// with a behavioural 1-Wire slave on the bus (CLKS_PER_US = 1).
`timescale 1ns/1ps
module tb_onewire_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, rsp_valid, rsp_presence, rsp_error, O_ONE_WIRE;
  logic [7:0] rsp_data, crc_o;
  logic       slave_rel = 1'b1;
  logic       i_bus;

  assign i_bus = O_ONE_WIRE & slave_rel;

  onewire_master #(.CLKS_PER_US(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_presence(rsp_presence), .rsp_error(rsp_error),
    .I_ONE_WIRE(i_bus), .O_ONE_WIRE(O_ONE_WIRE), .crc_o(crc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         acc;
    int         lat;
    logic [7:0] data;
    logic       pres;
    logic       err;
    logic [7:0] crc;
  } exp_t;

  exp_t       sb_q[$];
  int         w_q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         slave_mode = 0;   // 0 idle, 1 presence, 2 stuck low, 3 send slave_byte
  logic [7:0] slave_byte = 8'h00;
  int         slave_bit = 0;
  bit         abort_mode = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic [7:0] m_crc = 8'h00;
  logic       m_pres = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [7:0] crc_model(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 8'h8C;
      else r = r >> 1;
    end
    return r;
  endfunction

  // Behavioural slave: reacts to the master's edges one cycle at a time.
  initial begin : slave_model
    int   since_rise, since_fall;
    logic o_prev, cur_bit;
    since_rise = 10000; since_fall = 10000; o_prev = 1'b1; cur_bit = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (O_ONE_WIRE && !o_prev) since_rise = 0; else since_rise++;
      if (!O_ONE_WIRE && o_prev) begin
        since_fall = 0;
        cur_bit = slave_byte[slave_bit[2:0]];
        slave_bit++;
      end else since_fall++;
      case (slave_mode)
        1: slave_rel = !(since_rise >= 20 && since_rise < 140);
        2: slave_rel = 1'b0;
        3: slave_rel = !(cur_bit == 1'b0 && since_fall < 30);
        default: slave_rel = 1'b1;
      endcase
      o_prev = O_ONE_WIRE;
    end
  end

  // Low-pulse width monitor against the queue of expected widths.
  initial begin : pulse_mon
    logic o_prev;
    int   fall_cyc, w, ew;
    o_prev = 1'b1; fall_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst || abort_mode) begin
        o_prev = O_ONE_WIRE;
      end else begin
        if (!O_ONE_WIRE && o_prev) fall_cyc = cyc;
        else if (O_ONE_WIRE && !o_prev) begin
          w = cyc - fall_cyc;
          if (w_q.size() == 0) check("unexpected_low_pulse", w, 0);
          else begin
            ew = w_q.pop_front();
            check("low_width", w, ew);
          end
        end
        o_prev = O_ONE_WIRE;
      end
    end
  end

  // Response monitor: pops the scoreboard on every rsp_valid.
  initial begin : rsp_mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (sb_q.size() == 0) check("unexpected_rsp_valid", rsp_valid, 1'b0);
        else begin
          e = sb_q.pop_front();
          check("latency", cyc - e.acc, e.lat);
          check("rsp_data", rsp_data, e.data);
          check("rsp_presence", rsp_presence, e.pres);
          check("rsp_error", rsp_error, e.err);
          check("crc_o", crc_o, e.crc);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] data, input int mode,
                       input logic [7:0] sbyte, input bit hold_busy);
    exp_t       e;
    int         n;
    logic [7:0] rd;
    int         widths[$];
    slave_mode = mode; slave_byte = sbyte; slave_bit = 0;
    e.err = 1'b0;
    case (op)
      2'b00: begin
        e.lat = 961; m_pres = (mode == 1) || (mode == 2); e.err = (mode == 2);
        m_crc = 8'h00; widths.push_back(480);
      end
      2'b01: begin
        e.lat = 561;
        for (int i = 0; i < 8; i++) widths.push_back(data[i] ? 6 : 60);
      end
      2'b10: begin
        e.lat = 561;
        rd = (mode == 3) ? sbyte : 8'hFF;
        m_data = rd;
`ifdef ONEWIRE_CRC_EN
        m_crc = crc_model(m_crc, rd);
`endif
        for (int i = 0; i < 8; i++) widths.push_back(6);
      end
      default: begin
        e.lat = 1; e.err = 1'b1;
      end
    endcase
    e.data = m_data; e.pres = m_pres; e.crc = m_crc;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      check("accept_timeout", cmd_ready, 1'b1);
      cmd_valid = 1'b0;
      return;
    end
    e.acc = cyc;
    sb_q.push_back(e);
    foreach (widths[i]) w_q.push_back(widths[i]);
    @(negedge clk);
    if (hold_busy) begin
      cmd_op = 2'b11;
      for (int k = 0; k < 40; k++) begin
        if ((k % 10) == 0) check("busy_cmd_ready", cmd_ready, 1'b0);
        @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 1200) begin @(negedge clk); n++; end
    if (sb_q.size() != 0) begin
      check("rsp_timeout", sb_q.size(), 0);
      sb_q.delete(); w_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int         acc, n;
    logic [1:0] rop;
    logic [7:0] crc_bytes [8];
    crc_bytes = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA2};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_O_ONE_WIRE", O_ONE_WIRE, 1'b1);
    check("reset_cmd_ready", cmd_ready, 1'b1);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_data", rsp_data, 8'h00);
    check("reset_rsp_presence", rsp_presence, 1'b0);
    check("reset_rsp_error", rsp_error, 1'b0);
    check("reset_crc_o", crc_o, 8'h00);

    issue(2'b00, 8'h00, 1, 8'h00, 1'b0);   // reset with presence
    issue(2'b00, 8'h00, 0, 8'h00, 1'b0);   // reset, empty bus
    issue(2'b00, 8'h00, 2, 8'h00, 1'b0);   // reset, bus stuck low
    issue(2'b01, 8'hA5, 0, 8'h00, 1'b0);   // write 0xA5
    issue(2'b10, 8'h00, 3, 8'hF5, 1'b1);   // read 0xF5, busy cmd_valid ignored
    issue(2'b11, 8'h00, 0, 8'h00, 1'b0);   // reserved op

    // Abort a write at cycle 100 with rst.
    abort_mode = 1'b1; slave_mode = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 8'h00;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("abort_accept", cmd_ready, 1'b1);
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (cyc < acc + 100) @(negedge clk);
    check("abort_bus_low_before", O_ONE_WIRE, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_data = 8'h00; m_pres = 1'b0; m_crc = 8'h00;
    check("abort_O_ONE_WIRE", O_ONE_WIRE, 1'b1);
    check("abort_cmd_ready", cmd_ready, 1'b1);
    repeat (700) @(negedge clk);
    abort_mode = 1'b0;
    issue(2'b00, 8'h00, 1, 8'h00, 1'b0);

    // Randomized commands.
    for (int r = 0; r < 8; r++) begin
      rop = 2'($urandom_range(0, 3));
      case (rop)
        2'b00:   issue(rop, 8'h00, int'($urandom_range(0, 1)), 8'h00, 1'b0);
        2'b01:   issue(rop, 8'($urandom), 0, 8'h00, 1'b0);
        2'b10:   issue(rop, 8'h00, 3, 8'($urandom), 1'b0);
        default: issue(rop, 8'($urandom), 0, 8'h00, 1'b0);
      endcase
    end

    // ROM-style read sequence with its trailing CRC byte.
    issue(2'b00, 8'h00, 1, 8'h00, 1'b0);
    for (int b = 0; b < 8; b++) begin
      issue(2'b10, 8'h00, 3, crc_bytes[b], 1'b0);
`ifdef ONEWIRE_CRC_EN
      if (b == 6) check("crc_after_7_bytes", crc_o, 8'hA2);
      if (b == 7) check("crc_after_crc_byte", crc_o, 8'h00);
`else
      if (b == 6 || b == 7) check("crc_tied_off", crc_o, 8'h00);
`endif
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
